// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter, plus a
// round-robin scan helper usable from behavioural code.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_MAX  = 4;

  // First set bit of mask after base, wrapping modulo n; base itself is last. -1 if none.
  function automatic int rr_next(input int base, input logic [31:0] mask, input int n);
    for (int k = 1; k <= n; k++) begin
      int idx;
      idx = (base + k) % n;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: lowest-numbered set bit of mask starting just
// after base, wrapping around so base itself has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  mask_i,
  input  logic [ID_WIDTH-1:0] base_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_win;
  logic [ID_WIDTH:0]    w_sh_amt;
  logic [ID_WIDTH:0]    w_sum;
  logic [ID_WIDTH-1:0]  w_off;

  assign w_dbl    = {mask_i, mask_i};
  assign w_sh_amt = (ID_WIDTH+1)'(base_i) + (ID_WIDTH+1)'(1);
  assign w_win    = NUM_REQ'(w_dbl >> w_sh_amt);

  always_comb begin
    found_o = 1'b0;
    w_off   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (w_win[i]) begin
        found_o = 1'b1;
        w_off   = ID_WIDTH'(i);
      end
    end
  end

  // Offset is relative to base+1; fold back into range with one subtraction.
  assign w_sum = w_sh_amt + (ID_WIDTH+1)'(w_off);
  assign idx_o = (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) ? ID_WIDTH'(w_sum - (ID_WIDTH+1)'(NUM_REQ))
                                                    : ID_WIDTH'(w_sum);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with per-grant burst quota sharing one fifo_fwft write
// port among NUM_REQ valid/ready producers; zero-latency pass-through.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = $clog2(BURST_MAX+1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                fifo_wen_o,
  output logic [DATA_WIDTH-1:0]               fifo_wdata_o,
  input  logic                                fifo_full_i,
  output logic                                grant_vld_o,
  output logic [ID_WIDTH-1:0]                 grant_id_o
);

  arb_state_e           r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]  r_owner, w_owner_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;

  logic                 w_found, w_keep, w_gvld, w_xfer;
  logic [ID_WIDTH-1:0]  w_pick, w_sel;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
    .mask_i  (req_valid_i),
    .base_i  (r_owner),
    .found_o (w_found),
    .idx_o   (w_pick)
  );

  // Owner keeps the port while it still has data and quota left.
  assign w_keep = (r_state == ARB_BURST) && req_valid_i[r_owner] &&
                  (r_cnt < CNT_WIDTH'(BURST_MAX));
  assign w_sel  = w_keep ? r_owner : w_pick;
  assign w_gvld = w_keep | w_found;
  assign w_xfer = w_gvld & ~fifo_full_i & rst_n;

  assign grant_vld_o  = w_gvld;
  assign grant_id_o   = w_gvld ? w_sel : r_owner;
  assign fifo_wen_o   = w_xfer;
  assign fifo_wdata_o = req_data_i[grant_id_o];

  always_comb begin
    req_ready_o = '0;
    if (w_xfer) req_ready_o[w_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    if (w_xfer) begin
      if (w_keep) begin
        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
      end else begin
        w_owner_nxt = w_sel;
        w_cnt_nxt   = CNT_WIDTH'(1);
      end
      w_state_nxt = ARB_BURST;
      // Quota exhausted: force a rotation on the next cycle.
      if (w_cnt_nxt == CNT_WIDTH'(BURST_MAX)) begin
        w_state_nxt = ARB_IDLE;
        w_cnt_nxt   = '0;
      end
    end else if (!w_gvld) begin
      w_state_nxt = ARB_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= ID_WIDTH'(NUM_REQ-1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a behavioural
// round-robin/burst-quota model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0][DW-1:0] req_data_i = '0;
  logic [N-1:0]      req_ready_o;
  logic              fifo_wen_o;
  logic [DW-1:0]     fifo_wdata_o;
  logic              fifo_full_i = 1'b0;
  logic              grant_vld_o;
  logic [IW-1:0]     grant_id_o;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .fifo_wen_o   (fifo_wen_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_full_i  (fifo_full_i),
    .grant_vld_o  (grant_vld_o),
    .grant_id_o   (grant_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          gvld;
    logic [IW-1:0] gid;
    logic          wen;
    logic [DW-1:0] data;
    logic [N-1:0]  rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Producer-side view: pending beat per requester.
  logic [N-1:0]         pv = '0;
  logic [N-1:0][DW-1:0] pd = '0;

  // Model state: who holds the port, beats used in the current grant, and
  // whether a grant is live at all.
  int m_owner = N-1;
  int m_used  = 0;
  bit m_live  = 0;

  task automatic step(input bit full, input bit rst);
    exp_t e;
    int   sel;
    bit   xfer;
    rst_n       = rst;
    fifo_full_i = full;
    req_valid_i = pv;
    req_data_i  = pd;
    if (m_live && pv[m_owner] && m_used < BM) sel = m_owner;
    else sel = rr_next(m_owner, {28'b0, pv}, N);
    e.gvld = (sel >= 0);
    e.gid  = e.gvld ? IW'(sel) : IW'(m_owner);
    xfer   = e.gvld && !full && rst;
    e.wen  = xfer;
    e.data = pd[e.gid];
    e.rdy  = xfer ? N'(1) << sel : '0;
    exp_q.push_back(e);
    if (!rst) begin
      m_owner = N-1; m_used = 0; m_live = 0;
    end else if (xfer) begin
      if (sel == m_owner && m_live) m_used++;
      else begin m_owner = sel; m_used = 1; end
      m_live = 1;
      if (m_used == BM) begin m_live = 0; m_used = 0; end
      pv[sel] = 1'b0;
    end else if (!e.gvld) begin
      m_live = 0; m_used = 0;
    end
  endtask

  task automatic gen(input int pct);
    for (int i = 0; i < N; i++)
      if (!pv[i] && $urandom_range(0, 99) < pct) begin
        pv[i] = 1'b1;
        pd[i] = DW'($urandom);
      end
  endtask

  task automatic tick(input bit full, input bit rst);
    @(posedge clk); #1;
    step(full, rst);
  endtask

  // Monitor: compare DUT outputs with the queued expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant_vld_o !== e.gvld) begin
          failures++;
          $display("FAIL grant_vld got=%0b exp=%0b t=%0t", grant_vld_o, e.gvld, $time);
        end
        checks++;
        if (grant_id_o !== e.gid) begin
          failures++;
          $display("FAIL grant_id got=%0d exp=%0d t=%0t", grant_id_o, e.gid, $time);
        end
        checks++;
        if (fifo_wen_o !== e.wen) begin
          failures++;
          $display("FAIL fifo_wen got=%0b exp=%0b t=%0t", fifo_wen_o, e.wen, $time);
        end
        checks++;
        if (req_ready_o !== e.rdy) begin
          failures++;
          $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready_o, e.rdy, $time);
        end
        if (e.wen) begin
          checks++;
          if (fifo_wdata_o !== e.data) begin
            failures++;
            $display("FAIL fifo_wdata got=%h exp=%h t=%0t", fifo_wdata_o, e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    // Reset edge, then idle: grant_id must sit at N-1 with nothing granted.
    tick(0, 0);
    repeat (5) tick(0, 1);

    // Single requester streaming a known sequence with no bubbles.
    for (int c = 0; c < 10; c++) begin
      pv[2] = 1'b1;
      pd[2] = DW'(8'h10 + c);
      tick(0, 1);
    end
    repeat (2) tick(0, 1);

    // All requesters saturated: bursts of BM in strict rotation.
    repeat (20) begin gen(100); tick(0, 1); end

    // Reset in the middle of req1's burst, then saturation again.
    pv = '0;
    tick(0, 0);
    repeat (7) begin gen(100); tick(0, 1); end
    gen(100); tick(0, 0);
    repeat (8) begin gen(100); tick(0, 1); end

    // Random traffic with backpressure and rare resets.
    repeat (800) begin
      gen($urandom_range(10, 90));
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) >= 1);
    end

    pv = '0;
    repeat (3) tick(0, 1);
    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
